rgb2bayer_pack10: RTL and testbench
===================================

Name: rgb2bayer_pack10

Overview:
- Re-mosaics a 24-bit RGB pixel stream into a GBRG Bayer RAW10 stream, packed two pixels per 20-bit word.
- Output word layout and line ordering match what the ISP debayer consumes, so this block closes the loop for pattern injection and loopback test of the ISP path without a sensor.
- Sits between a pattern/RGB source and the debayer input.
- Valid/ready on both sides; frame and line alignment are carried by sof/eol flags.

Parameters:
- LINE_WORDS, 640, packed words per line; each line is 2*LINE_WORDS pixels; minimum 2.
- INVERT_RG, 1, when 1 the R and G input bytes are bitwise inverted before selection, undoing the debayer output inversion.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rgb_in  in  24  pixel, R=[23:16], G=[15:8], B=[7:0]
- rgb_sof  in  1  qualifies rgb_in as first pixel of a frame
- rgb_valid  in  1  rgb_in valid
- rgb_ready  out  1  block accepts rgb_in this cycle
- raw_out  out  20  packed word: [19:10] even-column pixel, [9:0] odd-column pixel
- raw_sof  out  1  with raw_valid: first word of frame
- raw_eol  out  1  with raw_valid: last word of line
- raw_valid  out  1  raw_out valid
- raw_ready  in  1  downstream accepts raw_out
- sync_err  out  1  sticky: sof arrived mid-line

Behaviour:
- Reset values:
  - raw_valid=0, raw_out=0, raw_sof=0, raw_eol=0, sync_err=0.
  - Internal state: phase=0, col=0, line_odd=0, pend=0, pend_sof=0.
- Handshake:
  - rgb_ready = ~raw_valid | raw_ready, registered-free combinational.
  - A pixel is accepted when rgb_valid & rgb_ready.
  - raw_valid is cleared on raw_valid & raw_ready unless a new word loads the same cycle.
  - raw_out and the flags stay stable while raw_valid=1 and raw_ready=0.
- Channel selection (after optional R/G inversion):
  - line_odd=0: even px -> G, odd px -> B.
  - line_odd=1: even px -> R, odd px -> G.
- Expansion: 8-bit s -> 10-bit {s, s[7:6]}, so 0x00->0x000 and 0xFF->0x3FF.
- Accept with phase=0:
  - pend <= expanded sample; pend_sof <= rgb_sof; phase <= 1.
  - No output is produced.
- Accept with phase=1 (second pixel of the pair):
  - raw_out <= {pend, expanded sample}.
  - raw_valid <= 1, raw_sof <= pend_sof, raw_eol <= (col==LINE_WORDS-1); phase <= 0.
  - Latency: word valid the cycle after the second pixel is accepted.
- Counters:
  - col increments per emitted word.
  - At col==LINE_WORDS-1: col <= 0 and line_odd toggles.
  - col wraps with no gap cycles required.
- rgb_sof accepted:
  - Forces frame alignment: line_odd=0, col=0.
  - The pixel is treated as the even pixel of a new pair: phase ends at 1, pend = that pixel, pend_sof=1.
  - If phase!=0 or col!=0 at that moment, the partial pair/line is discarded (no word emitted) and sync_err <= 1.
  - sof with phase=0 and col=0 is clean: no error.
- rgb_sof on an odd-phase accept is covered by the rule above: the partial pair is dropped and sync_err is set.
- sync_err clears only on rst.
- Backpressure: while raw_valid=1 and raw_ready=0, rgb_ready=0. No pixel is lost and none is duplicated.
- Reset mid-line: all state returns to reset values. The first accepted pixel afterwards is an even pixel of line 0.

Test Plan:
- INVERT_RG=0, LINE_WORDS=4, pixels 24'h102030 x8 after sof, raw_ready=1 -> words 0..3 = 20'h200C0, raw_sof on word 0, raw_eol on word 3; next line words = 20'h10080.
- INVERT_RG=1, pixel 24'h0000FF on line 0 pair -> G inverted 0xFF=0x3FF, B=0x3FF -> raw_out 20'hFFFFF.
- raw_ready toggled randomly over 3 frames of 4x4 words -> every word exactly once, in order, stable while stalled; rgb_ready low whenever raw_valid & ~raw_ready.
- sof injected after 3 pixels of a line -> partial pair dropped, sync_err=1 and stays 1, next word carries raw_sof with line_odd=0 mapping.
- Back-to-back frames with gap-free valid -> raw_eol every 4th word, line mapping alternates G/B, R/G, sync_err stays 0.
- Assert rst mid-line then restart with sof -> all outputs 0 during reset, first word after is the line-0 G/B mapping.

Source files
------------

// File: rtl/rgb2bayer_pack10.sv
`default_nettype none
// ============================================================================
// Module  : rgb2bayer_pack10
// Brief   : Re-mosaics 24-bit RGB into GBRG Bayer RAW10, two pixels per word.
// Revision: 1.0
// ============================================================================
module rgb2bayer_pack10 #(
  parameter int LINE_WORDS = 640,
  parameter bit INVERT_RG  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  input  logic        rgb_sof,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  output logic [19:0] raw_out,
  output logic        raw_sof,
  output logic        raw_eol,
  output logic        raw_valid,
  input  logic        raw_ready,
  output logic        sync_err
);

  localparam int               COL_W    = $clog2(LINE_WORDS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  phase_t           phase_q;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;
  logic             line_odd_q;
  logic             line_odd_d;
  logic [9:0]       pend_q;
  logic             pend_sof_q;
  logic [19:0]      raw_out_q;
  logic             raw_sof_q;
  logic             raw_eol_q;
  logic             raw_valid_q;
  logic             sync_err_q;

  logic [7:0]       w_red;
  logic [7:0]       w_grn;
  logic [7:0]       w_smp;
  logic [9:0]       w_exp;
  logic             w_even;
  logic             w_lodd;
  logic             w_accept;
  logic             w_mid;

  generate
    if (INVERT_RG) begin : g_inv
      assign w_red = ~rgb_in[23:16];
      assign w_grn = ~rgb_in[15:8];
    end else begin : g_noinv
      assign w_red = rgb_in[23:16];
      assign w_grn = rgb_in[15:8];
    end
  endgenerate

  assign rgb_ready = ~raw_valid_q | raw_ready;
  assign w_accept  = rgb_valid & rgb_ready;

  // A sof pixel always lands as the even pixel of line 0, whatever the counters say.
  always_comb begin
    w_even = rgb_sof | (phase_q == PH_EVEN);
    w_lodd = rgb_sof ? 1'b0 : line_odd_q;
    if (w_lodd) begin
      w_smp = w_even ? w_red : w_grn;
    end else begin
      w_smp = w_even ? w_grn : rgb_in[7:0];
    end
  end

  assign w_exp      = {w_smp, w_smp[7:6]};
  assign col_d      = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign line_odd_d = (col_q == COL_LAST) ? ~line_odd_q : line_odd_q;
  assign w_mid      = (phase_q != PH_EVEN) | (col_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_EVEN;
      col_q       <= '0;
      line_odd_q  <= 1'b0;
      pend_q      <= '0;
      pend_sof_q  <= 1'b0;
      raw_out_q   <= '0;
      raw_sof_q   <= 1'b0;
      raw_eol_q   <= 1'b0;
      raw_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      if (raw_valid_q && raw_ready) begin
        raw_valid_q <= 1'b0;
      end
      if (w_accept) begin
        if (rgb_sof) begin
          // Realign to a new frame; any partial pair or line is dropped.
          if (w_mid) begin
            sync_err_q <= 1'b1;
          end
          line_odd_q <= 1'b0;
          col_q      <= '0;
          pend_q     <= w_exp;
          pend_sof_q <= 1'b1;
          phase_q    <= PH_ODD;
        end else if (phase_q == PH_EVEN) begin
          pend_q     <= w_exp;
          pend_sof_q <= 1'b0;
          phase_q    <= PH_ODD;
        end else begin
          raw_out_q   <= {pend_q, w_exp};
          raw_valid_q <= 1'b1;
          raw_sof_q   <= pend_sof_q;
          raw_eol_q   <= (col_q == COL_LAST);
          phase_q     <= PH_EVEN;
          col_q       <= col_d;
          line_odd_q  <= line_odd_d;
        end
      end
    end
  end

  assign raw_out   = raw_out_q;
  assign raw_sof   = raw_sof_q;
  assign raw_eol   = raw_eol_q;
  assign raw_valid = raw_valid_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb2bayer_pack10.sv
`default_nettype none
// ============================================================================
// Module  : tb_rgb2bayer_pack10
// Brief   : Directed self-checking bench for rgb2bayer_pack10 (4 words/line).
// Revision: 1.0
// ============================================================================
module tb_rgb2bayer_pack10;

  localparam int LW    = 4;
  localparam int LINES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [23:0] rgb_in = '0;
  logic        rgb_sof = 1'b0;
  logic        rgb_valid = 1'b0;
  logic        rgb_ready;
  logic [19:0] raw_out;
  logic        raw_sof;
  logic        raw_eol;
  logic        raw_valid;
  logic        raw_ready = 1'b1;
  logic        sync_err;

  logic [23:0] rgb1_in = '0;
  logic        rgb1_sof = 1'b0;
  logic        rgb1_valid = 1'b0;
  logic        rgb1_ready;
  logic [19:0] raw1_out;
  logic        raw1_sof;
  logic        raw1_eol;
  logic        raw1_valid;
  logic        raw1_ready = 1'b1;
  logic        sync1_err;

  always #5 clk = ~clk;

  rgb2bayer_pack10 #(.LINE_WORDS(LW), .INVERT_RG(1'b0)) dut (
    .clk(clk), .rst(rst),
    .rgb_in(rgb_in), .rgb_sof(rgb_sof), .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .raw_out(raw_out), .raw_sof(raw_sof), .raw_eol(raw_eol), .raw_valid(raw_valid),
    .raw_ready(raw_ready), .sync_err(sync_err)
  );

  rgb2bayer_pack10 #(.LINE_WORDS(LW), .INVERT_RG(1'b1)) dut_inv (
    .clk(clk), .rst(rst),
    .rgb_in(rgb1_in), .rgb_sof(rgb1_sof), .rgb_valid(rgb1_valid), .rgb_ready(rgb1_ready),
    .raw_out(raw1_out), .raw_sof(raw1_sof), .raw_eol(raw1_eol), .raw_valid(raw1_valid),
    .raw_ready(raw1_ready), .sync_err(sync1_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ex10(input logic [7:0] s);
    return {s, s[7:6]};
  endfunction

  // GBRG: even lines carry G,B pairs; odd lines carry R,G pairs.
  function automatic logic [19:0] mk_word(input logic [23:0] p0, input logic [23:0] p1,
                                          input logic lodd);
    if (lodd) return {ex10(p0[23:16]), ex10(p1[15:8])};
    return {ex10(p0[15:8]), ex10(p1[7:0])};
  endfunction

  function automatic logic [23:0] pxv(input int i);
    return {8'(i * 37 + 5), 8'(i * 11 + 90), 8'(i * 73 + 200)};
  endfunction

  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];
  bit          bp_en = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    raw_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Collector: a word transfers at the next edge when valid & ready hold here.
  initial begin
    logic        stall;
    logic [21:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(raw_valid), 32'd1);
          chk("stall_data", 32'({raw_sof, raw_eol, raw_out}), 32'(held));
        end
        if (raw_valid && !raw_ready) begin
          chk("rgb_ready_low", 32'(rgb_ready), 32'd0);
          held  = {raw_sof, raw_eol, raw_out};
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
        if (raw_valid && raw_ready) got_q.push_back({raw_sof, raw_eol, raw_out});
      end
    end
  end

  task automatic send_px(input logic [23:0] px, input logic sof);
    logic acc;
    rgb_in    = px;
    rgb_sof   = sof;
    rgb_valid = 1'b1;
    acc       = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = rgb_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    rgb_valid = 1'b0;
    rgb_sof   = 1'b0;
  endtask

  task automatic send_frames(input int base, input int nframes);
    logic [23:0] p0;
    logic [23:0] p1;
    logic        first;
    int          k;
    k = base;
    for (int f = 0; f < nframes; f++) begin
      for (int l = 0; l < LINES; l++) begin
        for (int w = 0; w < LW; w++) begin
          p0    = pxv(k);
          p1    = pxv(k + 1);
          k     = k + 2;
          first = (l == 0) && (w == 0);
          send_px(p0, first);
          send_px(p1, 1'b0);
          exp_q.push_back({first, (w == LW - 1), mk_word(p0, p1, 1'(l % 2))});
        end
      end
    end
    idle_in();
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 2000 && got_q.size() < exp_q.size(); n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(raw_valid), 32'd0);
    chk("rst_out", 32'(raw_out), 32'd0);
    chk("rst_sof", 32'(raw_sof), 32'd0);
    chk("rst_eol", 32'(raw_eol), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_rgb_ready", 32'(rgb_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two lines of a flat 0x102030 field: G/B then R/G
    for (int i = 0; i < 2 * LW * 2; i++) send_px(24'h102030, i == 0);
    idle_in();
    for (int i = 0; i < LW; i++) exp_q.push_back({(i == 0), (i == LW - 1), 20'h200C0});
    for (int i = 0; i < LW; i++) exp_q.push_back({1'b0, (i == LW - 1), 20'h10080});
    drain("flat_word");
    chk("flat_sync_err", 32'(sync_err), 32'd0);

    // R/G inversion variant
    rgb1_in    = 24'h0000FF;
    rgb1_sof   = 1'b1;
    rgb1_valid = 1'b1;
    @(posedge clk);
    #1;
    rgb1_sof = 1'b0;
    @(posedge clk);
    #1;
    rgb1_in = 24'h80C040;
    @(negedge clk);
    chk("inv_valid", 32'(raw1_valid), 32'd1);
    chk("inv_word", 32'(raw1_out), 32'hFFFFF);
    chk("inv_sof", 32'(raw1_sof), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rgb1_valid = 1'b0;
    @(negedge clk);
    chk("inv_word2", 32'(raw1_out), 32'h3F101);
    chk("inv_sof2", 32'(raw1_sof), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back gap-free frames
    send_frames(0, 2);
    drain("b2b_word");
    chk("b2b_sync_err", 32'(sync_err), 32'd0);

    // Random downstream backpressure over three frames
    bp_en = 1'b1;
    send_frames(1000, 3);
    drain("bp_word");
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_sync_err", 32'(sync_err), 32'd0);

    // sof after three pixels of a line
    send_px(24'h102030, 1'b1);
    send_px(24'h102030, 1'b0);
    send_px(24'hAABBCC, 1'b0);
    send_px(24'h102030, 1'b1);
    for (int i = 0; i < 7; i++) send_px(24'h102030, 1'b0);
    idle_in();
    exp_q.push_back({1'b1, 1'b0, 20'h200C0});
    exp_q.push_back({1'b1, 1'b0, 20'h200C0});
    exp_q.push_back({1'b0, 1'b0, 20'h200C0});
    exp_q.push_back({1'b0, 1'b0, 20'h200C0});
    exp_q.push_back({1'b0, 1'b1, 20'h200C0});
    drain("sofinj_word");
    chk("sofinj_sync_err", 32'(sync_err), 32'd1);
    for (int i = 0; i < 2 * LW; i++) send_px(24'h102030, 1'b0);
    idle_in();
    for (int i = 0; i < LW; i++) exp_q.push_back({1'b0, (i == LW - 1), 20'h10080});
    drain("sofinj_next");
    chk("sofinj_sticky", 32'(sync_err), 32'd1);

    // Reset in the middle of a line
    for (int i = 0; i < 3; i++) send_px(24'h102030, 1'b0);
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(raw_valid), 32'd0);
    chk("mid_rst_out", 32'(raw_out), 32'd0);
    chk("mid_rst_sof", 32'(raw_sof), 32'd0);
    chk("mid_rst_eol", 32'(raw_eol), 32'd0);
    chk("mid_rst_sync_err", 32'(sync_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    send_px(24'h102030, 1'b1);
    send_px(24'h102030, 1'b0);
    idle_in();
    exp_q.push_back({1'b1, 1'b0, 20'h200C0});
    drain("post_rst_word");
    chk("post_rst_sync_err", 32'(sync_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
